// File: rtl/apb_master_arbiter_if.sv
// Requester and APB bus signals of the two-requester APB master arbiter.
// The master modport is the arbiter's view; slave is the requester/APB-slave view.
interface apb_master_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [1:0]  req0_slv;
  logic [1:0]  req1_slv;
  logic        req0_write;
  logic        req1_write;
  logic [31:0] req0_addr;
  logic [31:0] req1_addr;
  logic [31:0] req0_wdata;
  logic [31:0] req1_wdata;
  logic        req0_done;
  logic        req1_done;
  logic        req0_err;
  logic        req1_err;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        busy;

  modport master (
    input  req0_valid, req1_valid, req0_slv, req1_slv, req0_write, req1_write,
           req0_addr, req1_addr, req0_wdata, req1_wdata, pready,
    output req0_done, req1_done, req0_err, req1_err,
           psel, penable, pwrite, paddr, pwdata, busy
  );

  modport slave (
    output req0_valid, req1_valid, req0_slv, req1_slv, req0_write, req1_write,
           req0_addr, req1_addr, req0_wdata, req1_wdata, pready,
    input  req0_done, req1_done, req0_err, req1_err,
           psel, penable, pwrite, paddr, pwdata, busy
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter driving one APB master port for two requesters; SETUP one edge after grant.
// Requesters hold valid until done/err; an ACCESS with no pready aborts after TIMEOUT cycles.
module apb_master_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  apb_master_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant_q;
  logic        any_vld;
  logic        pick;
  logic [1:0]  pick_slv;
  logic [1:0]  slv_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt;

  // The requester not granted last wins a tie; a lone requester always wins.
  always_comb begin
    any_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) pick = ~last_grant;
    else                                  pick = bus.req1_valid;
    pick_slv = pick ? bus.req1_slv : bus.req0_slv;
  end

  always_comb begin
    state_nxt     = state;
    bus.psel      = 2'd0;
    bus.penable   = 1'b0;
    bus.pwrite    = 1'b0;
    bus.paddr     = 32'd0;
    bus.pwdata    = 32'd0;
    bus.req0_done = 1'b0;
    bus.req1_done = 1'b0;
    bus.req0_err  = 1'b0;
    bus.req1_err  = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_vld) state_nxt = (pick_slv == 2'd0) ? ERR : SETUP;
      end
      SETUP: begin
        bus.psel   = slv_q;
        bus.pwrite = write_q;
        bus.paddr  = addr_q;
        bus.pwdata = wdata_q;
        state_nxt  = ACCESS;
      end
      ACCESS: begin
        bus.psel    = slv_q;
        bus.penable = 1'b1;
        bus.pwrite  = write_q;
        bus.paddr   = addr_q;
        bus.pwdata  = wdata_q;
        if (bus.pready)                      state_nxt = DONE;
        else if (cnt >= TO_LIMIT - 16'd1)    state_nxt = ERR;
      end
      DONE: begin
        bus.req0_done = ~grant_q;
        bus.req1_done = grant_q;
        state_nxt     = IDLE;
      end
      ERR: begin
        bus.req0_err = ~grant_q;
        bus.req1_err = grant_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      slv_q      <= 2'd0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cnt        <= 16'd0;
    end else begin
      state <= state_nxt;
      // Request fields are captured only at grant; later changes are ignored.
      if (state == IDLE && any_vld) begin
        last_grant <= pick;
        grant_q    <= pick;
        slv_q      <= pick_slv;
        write_q    <= pick ? bus.req1_write : bus.req0_write;
        addr_q     <= pick ? bus.req1_addr  : bus.req0_addr;
        wdata_q    <= pick ? bus.req1_wdata : bus.req0_wdata;
      end
      if (state == IDLE && state_nxt == SETUP)    cnt <= 16'd0;
      else if (state == ACCESS && cnt != TO_LIMIT) cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench: transaction-level model checked every cycle plus hand-computed literals.
module tb_apb_master_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_arbiter_if bus ();
  apb_master_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int slave_delay = 0;
  bit force_rdy = 1'b0;
  int n_psel, n_pen, n_busy, n_done0, n_done1, n_err0, n_err1;
  int done_order[$];

  // Model of the transfer in flight: age 0 is the setup cycle, age k the k-th access cycle;
  // m_end marks the closing cycle (1 = done, 2 = err).
  bit          m_active;
  int          m_who, m_age, m_end, m_last;
  logic [1:0]  m_slv;
  logic        m_write;
  logic [31:0] m_addr, m_wdata;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [72:0] dut_vec();
    return {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
            bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err, bus.busy};
  endfunction

  function automatic logic [72:0] exp_vec();
    logic [1:0]  ps;
    logic        pe, pw, d0, d1, e0, e1;
    logic [31:0] pa, pd;
    ps = 2'd0; pe = 1'b0; pw = 1'b0; pa = 32'd0; pd = 32'd0;
    d0 = 1'b0; d1 = 1'b0; e0 = 1'b0; e1 = 1'b0;
    if (m_end == 1) begin
      d0 = (m_who == 0); d1 = (m_who == 1);
    end else if (m_end == 2) begin
      e0 = (m_who == 0); e1 = (m_who == 1);
    end else if (m_active) begin
      ps = m_slv; pe = (m_age > 0); pw = m_write; pa = m_addr; pd = m_wdata;
    end
    return {ps, pe, pw, pa, pd, d0, d1, e0, e1, m_active};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_who = 0; m_age = 0; m_end = 0; m_last = 1;
    m_slv = 2'd0; m_write = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
  endtask

  task automatic model_step();
    if (m_end != 0) begin
      m_end = 0;
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_age == 0)          m_age = 1;
      else if (bus.pready)     m_end = 1;
      else if (m_age >= TO)    m_end = 2;
      else                     m_age++;
    end else if (bus.req0_valid || bus.req1_valid) begin
      if (bus.req0_valid && bus.req1_valid) m_who = 1 - m_last;
      else                                  m_who = bus.req1_valid ? 1 : 0;
      m_last   = m_who;
      m_slv    = (m_who == 1) ? bus.req1_slv   : bus.req0_slv;
      m_write  = (m_who == 1) ? bus.req1_write : bus.req0_write;
      m_addr   = (m_who == 1) ? bus.req1_addr  : bus.req0_addr;
      m_wdata  = (m_who == 1) ? bus.req1_wdata : bus.req0_wdata;
      m_active = 1'b1;
      m_age    = 0;
      m_end    = (m_slv == 2'd0) ? 2 : 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Every cycle out of reset: compare against the model and tally bus activity.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cycle", dut_vec(), exp_vec());
        if (bus.psel != 2'd0) n_psel++;
        if (bus.penable)      n_pen++;
        if (bus.busy)         n_busy++;
        if (bus.req0_done) begin n_done0++; done_order.push_back(0); end
        if (bus.req1_done) begin n_done1++; done_order.push_back(1); end
        if (bus.req0_err)     n_err0++;
        if (bus.req1_err)     n_err1++;
      end
    end
  end

  // Slave: pready in the slave_delay-th access cycle (0 = never); force_rdy drives it outside ACCESS.
  initial begin
    int acc;
    acc = 0;
    bus.pready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.penable) acc++;
      else             acc = 0;
      bus.pready = (force_rdy && !bus.penable) || (slave_delay != 0 && acc == slave_delay);
    end
  end

  task automatic clear_counts();
    n_psel = 0; n_pen = 0; n_busy = 0;
    n_done0 = 0; n_done1 = 0; n_err0 = 0; n_err1 = 0;
    done_order.delete();
  endtask

  task automatic set_req(input int n, input logic [1:0] slv, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      bus.req0_slv = slv; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_slv = slv; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
      bus.req1_valid = 1'b1;
    end
  endtask

  task automatic run_until_quiet(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.req0_done || bus.req0_err) bus.req0_valid = 1'b0;
      if (bus.req1_done || bus.req1_err) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && !bus.req1_valid && !bus.busy) break;
    end
    chk("settle_within_budget", 73'(k < budget), 73'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_slv = 2'd0;   bus.req1_slv = 2'd0;
    bus.req0_write = 1'b0; bus.req1_write = 1'b0;
    bus.req0_addr = 32'd0; bus.req1_addr = 32'd0;
    bus.req0_wdata = 32'd0; bus.req1_wdata = 32'd0;
    clear_counts();
    #1 chk("reset_outputs", dut_vec(), 73'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", dut_vec(), 73'd0);

    // Single write, pready in the third access cycle.
    clear_counts(); slave_delay = 3;
    set_req(0, 2'd1, 1'b1, 32'h10, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("setup_after_edge1", {bus.psel, bus.penable}, {2'd1, 1'b0});
    @(posedge clk); #1;
    chk("access_after_edge2", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
        {2'd1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5});
    run_until_quiet(20);
    chk("wr_penable_cycles", n_pen, 3);
    chk("wr_psel_cycles", n_psel, 4);
    chk("wr_done_err", {n_done0, n_err0}, {32'd1, 32'd0});

    // Reset restores last-grant=1: req0 first, then req1 after one idle cycle.
    do_reset(); clear_counts(); slave_delay = 1;
    set_req(0, 2'd1, 1'b1, 32'h100, 32'h11110000);
    set_req(1, 2'd3, 1'b0, 32'h200, 32'h22220000);
    run_until_quiet(30);
    chk("rr_count", done_order.size(), 2);
    if (done_order.size() == 2) chk("rr_order_req0_first", {done_order[0], done_order[1]}, {32'd0, 32'd1});
    chk("rr_busy_cycles", n_busy, 6);

    // A lone req0 leaves last-grant=0, so a tie now goes to req1.
    clear_counts(); slave_delay = 2;
    set_req(0, 2'd2, 1'b1, 32'h300, 32'h3);
    run_until_quiet(20);
    clear_counts();
    set_req(0, 2'd1, 1'b0, 32'h310, 32'h31);
    set_req(1, 2'd2, 1'b1, 32'h320, 32'h32);
    run_until_quiet(30);
    chk("rr2_count", done_order.size(), 2);
    if (done_order.size() == 2) chk("rr2_order_req1_first", {done_order[0], done_order[1]}, {32'd1, 32'd0});

    // Timeout: no pready at all.
    clear_counts(); slave_delay = 0;
    set_req(1, 2'd2, 1'b1, 32'h400, 32'h4);
    run_until_quiet(20);
    chk("to_access_cycles", n_pen, TO);
    chk("to_err_done", {n_err1, n_done0 + n_done1}, {32'd1, 32'd0});
    chk("to_psel_idle", bus.psel, 2'd0);

    // pready in the last allowed access cycle still completes.
    clear_counts(); slave_delay = TO;
    set_req(0, 2'd3, 1'b0, 32'h480, 32'h48);
    run_until_quiet(20);
    chk("edge_access_cycles", n_pen, TO);
    chk("edge_done_err", {n_done0, n_err0}, {32'd1, 32'd0});

    // Illegal slave ID: no bus cycle, err on the cycle after grant.
    clear_counts();
    set_req(0, 2'd0, 1'b1, 32'h500, 32'h5);
    @(posedge clk); #1;
    chk("illegal_err_now", {bus.req0_err, bus.psel, bus.busy}, {1'b1, 2'd0, 1'b1});
    run_until_quiet(10);
    chk("illegal_no_psel", n_psel, 0);
    chk("illegal_err_done", {n_err0, n_done0}, {32'd1, 32'd0});

    // Reset during ACCESS clears outputs without a clock edge.
    clear_counts(); slave_delay = 0;
    set_req(0, 2'd1, 1'b1, 32'h600, 32'h6);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("reset_mid_access", dut_vec(), 73'd0);
    bus.req0_valid = 1'b0;
    chk("reset_no_pulse", {n_done0, n_err0}, {32'd0, 32'd0});
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    clear_counts(); slave_delay = 2;
    set_req(0, 2'd1, 1'b0, 32'h610, 32'h0);
    run_until_quiet(20);
    chk("after_reset_done", {n_done0, n_pen}, {32'd1, 32'd2});

    // pready high in IDLE and SETUP is ignored.
    clear_counts(); force_rdy = 1'b1; slave_delay = 2;
    @(negedge clk);
    set_req(1, 2'd1, 1'b0, 32'h700, 32'h7);
    @(posedge clk); #1;
    chk("setup_with_pready", {bus.psel, bus.penable, bus.pready}, {2'd1, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("still_access", {bus.penable, bus.req1_done}, {1'b1, 1'b0});
    run_until_quiet(20);
    force_rdy = 1'b0;
    chk("ignored_rdy_cycles", n_pen, 2);
    chk("ignored_rdy_done", n_done1, 1);

    // Input changes and a dropped valid mid-transfer do not disturb it.
    clear_counts(); slave_delay = 3;
    set_req(0, 2'd2, 1'b1, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus.req0_addr = 32'h99; bus.req0_slv = 2'd3; bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("held_fields", {bus.psel, bus.paddr, bus.pwdata}, {2'd2, 32'h40, 32'hDEADBEEF});
    run_until_quiet(20);
    chk("dropped_valid_done", n_done0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
